// File: rtl/otter_mem_model.sv
// Shared byte-writable word memory for otter_mcu harnesses: pipelined imem/dmem reads,
// preload port, sticky out-of-range flag and load/store counters.
module otter_mem_model #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] OOB_DATA   = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           imem_addr_i,
  output logic [31:0]           imem_r_data_o,
  input  logic                  dmem_r_en_i,
  input  logic                  dmem_w_en_i,
  input  logic [3:0]            dmem_w_strb_i,
  input  logic [31:0]           dmem_addr_i,
  input  logic [31:0]           dmem_w_data_i,
  output logic [31:0]           dmem_r_data_o,
  output logic                  dmem_r_valid_o,
  input  logic                  init_we_i,
  input  logic [DEPTH_LOG2-1:0] init_addr_i,
  input  logic [31:0]           init_data_i,
  output logic                  err_oob_o,
  output logic [CNT_W-1:0]      load_cnt_o,
  output logic [CNT_W-1:0]      store_cnt_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("otter_mem_model: RD_LATENCY must be in 1..4");
  end

  logic [31:0] mem_q [Depth];

  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic                  i_oob, d_oob;
  logic [31:0]           i_rd, d_rd;
  logic                  init_hit, store_ok;
  logic                  unused_addr_bits;

  assign i_idx = imem_addr_i[DEPTH_LOG2+1:2];
  assign d_idx = dmem_addr_i[DEPTH_LOG2+1:2];
  assign i_oob = |imem_addr_i[31:DEPTH_LOG2+2];
  assign d_oob = |dmem_addr_i[31:DEPTH_LOG2+2];
  // Byte selection is by strobe only; the low address bits carry no information.
  assign unused_addr_bits = ^{imem_addr_i[1:0], dmem_addr_i[1:0]};

  assign i_rd = i_oob ? OOB_DATA : mem_q[i_idx];
  assign d_rd = d_oob ? OOB_DATA : mem_q[d_idx];

  // Preload wins over a dmem store to the same word at the same edge.
  assign init_hit = init_we_i && (init_addr_i == d_idx);
  assign store_ok = dmem_w_en_i && !d_oob && (dmem_w_strb_i != 4'b0) && !init_hit;

  // Contents deliberately survive reset; accesses are only ignored while it is held.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (init_we_i) begin
        mem_q[init_addr_i] <= init_data_i;
      end
      if (store_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (dmem_w_strb_i[b]) begin
            mem_q[d_idx][8*b +: 8] <= dmem_w_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  logic [31:0]           i_pipe_q [RD_LATENCY];
  logic [31:0]           d_pipe_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] d_vld_q;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]      store_cnt_q, store_cnt_d;

  always_comb begin
    err_d       = err_q | i_oob | (d_oob & (dmem_r_en_i | dmem_w_en_i));
    load_cnt_d  = load_cnt_q + CNT_W'(dmem_r_en_i);
    store_cnt_d = store_cnt_q + CNT_W'(store_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        i_pipe_q[s] <= '0;
        d_pipe_q[s] <= '0;
      end
      d_vld_q     <= '0;
      err_q       <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      i_pipe_q[0] <= i_rd;
      d_pipe_q[0] <= d_rd;
      d_vld_q[0]  <= dmem_r_en_i;
      for (int s = 1; s < RD_LATENCY; s++) begin
        i_pipe_q[s] <= i_pipe_q[s-1];
        d_pipe_q[s] <= d_pipe_q[s-1];
        d_vld_q[s]  <= d_vld_q[s-1];
      end
      err_q       <= err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign imem_r_data_o  = i_pipe_q[RD_LATENCY-1];
  assign dmem_r_valid_o = d_vld_q[RD_LATENCY-1];
  assign dmem_r_data_o  = dmem_r_valid_o ? d_pipe_q[RD_LATENCY-1] : 32'h0;
  assign err_oob_o      = err_q;
  assign load_cnt_o     = load_cnt_q;
  assign store_cnt_o    = store_cnt_q;

endmodule

// File: tb/tb_otter_mem_model.sv
// Bench for otter_mem_model: directed scenarios with literal expectations, then random traffic
// checked every cycle against a latency-queue model of the memory.
module tb_otter_mem_model;

  localparam int unsigned DepthLog2 = 10;
  localparam int unsigned Lat       = 2;
  localparam int unsigned CntW      = 4;
  localparam logic [31:0] OobData   = 32'hDEAD_BEEF;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          imem_addr, imem_r_data;
  logic                 r_en, w_en;
  logic [3:0]           strb;
  logic [31:0]          daddr, wdata, dmem_r_data;
  logic                 dmem_r_valid;
  logic                 init_we;
  logic [DepthLog2-1:0] init_addr;
  logic [31:0]          init_data;
  logic                 err_oob;
  logic [CntW-1:0]      load_cnt, store_cnt;

  otter_mem_model #(
    .DEPTH_LOG2(DepthLog2),
    .RD_LATENCY(Lat),
    .OOB_DATA  (OobData),
    .CNT_W     (CntW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_addr_i   (imem_addr),
    .imem_r_data_o (imem_r_data),
    .dmem_r_en_i   (r_en),
    .dmem_w_en_i   (w_en),
    .dmem_w_strb_i (strb),
    .dmem_addr_i   (daddr),
    .dmem_w_data_i (wdata),
    .dmem_r_data_o (dmem_r_data),
    .dmem_r_valid_o(dmem_r_valid),
    .init_we_i     (init_we),
    .init_addr_i   (init_addr),
    .init_data_i   (init_data),
    .err_oob_o     (err_oob),
    .load_cnt_o    (load_cnt),
    .store_cnt_o   (store_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: word array, result queues of length Lat, plain counters.
  logic [31:0] shadow [1024];
  logic [31:0] q_i[$];
  logic [32:0] q_d[$];
  logic [31:0] exp_i, exp_dd;
  logic        exp_dv;
  bit          m_err;
  int          m_load, m_store;
  logic [31:0] pre0;

  function automatic bit is_oob(logic [31:0] a);
    return a[31:DepthLog2+2] != '0;
  endfunction

  task automatic model_reset();
    q_i.delete();
    q_d.delete();
    for (int k = 0; k < int'(Lat) - 1; k++) begin
      q_i.push_back(32'h0);
      q_d.push_back(33'h0);
    end
    exp_i   = 32'h0;
    exp_dd  = 32'h0;
    exp_dv  = 1'b0;
    m_err   = 1'b0;
    m_load  = 0;
    m_store = 0;
  endtask

  task automatic model_edge();
    logic [31:0] ri, rd, w;
    logic [32:0] dv;
    int          wi;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ri = is_oob(imem_addr) ? OobData : shadow[imem_addr[11:2]];
    rd = is_oob(daddr) ? OobData : shadow[daddr[11:2]];
    q_i.push_back(ri);
    q_d.push_back({r_en, rd});
    exp_i  = q_i.pop_front();
    dv     = q_d.pop_front();
    exp_dv = dv[32];
    exp_dd = dv[32] ? dv[31:0] : 32'h0;
    if (is_oob(imem_addr) || (is_oob(daddr) && (r_en || w_en))) m_err = 1'b1;
    if (r_en) m_load++;
    wi = int'(daddr[11:2]);
    if (w_en && !is_oob(daddr) && strb != 4'h0 && !(init_we && int'(init_addr) == wi)) begin
      w = shadow[wi];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      shadow[wi] = w;
      m_store++;
    end
    if (init_we) shadow[init_addr] = init_data;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("imem_r_data", imem_r_data, exp_i);
    check("dmem_r_valid", 32'(dmem_r_valid), 32'(exp_dv));
    check("dmem_r_data", dmem_r_data, exp_dd);
    check("err_oob", 32'(err_oob), 32'(m_err));
    check("load_cnt", 32'(load_cnt), 32'(m_load % (1 << CntW)));
    check("store_cnt", 32'(store_cnt), 32'(m_store % (1 << CntW)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic idle();
    r_en    = 1'b0;
    w_en    = 1'b0;
    strb    = 4'h0;
    daddr   = 32'h0;
    wdata   = 32'h0;
    init_we = 1'b0;
  endtask

  task automatic do_init(int unsigned idx, logic [31:0] data);
    init_we   = 1'b1;
    init_addr = DepthLog2'(idx);
    init_data = data;
    step();
    init_we = 1'b0;
  endtask

  task automatic do_write(logic [31:0] a, logic [3:0] s, logic [31:0] d);
    w_en  = 1'b1;
    daddr = a;
    strb  = s;
    wdata = d;
    step();
    w_en = 1'b0;
    strb = 4'h0;
  endtask

  task automatic rd_check(string name, logic [31:0] a, logic [31:0] exp);
    r_en  = 1'b1;
    daddr = a;
    step();
    r_en = 1'b0;
    step();
    check({name, "_data"}, dmem_r_data, exp);
    check({name, "_valid"}, 32'(dmem_r_valid), 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    rst_n     = 1'b0;
    imem_addr = 32'h0;
    init_addr = '0;
    init_data = 32'h0;
    idle();
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    // Preload the low 16 words so every word the bench touches has known contents.
    for (int w = 0; w < 16; w++) do_init(w, $urandom);
    pre0  = shadow[0];
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();
    check("reset_err", 32'(err_oob), 32'h0);
    check("reset_load", 32'(load_cnt), 32'h0);

    // Fetch latency from a preloaded word.
    do_init(4, 32'h1234_5678);
    imem_addr = 32'h10;
    step();
    imem_addr = 32'h0;
    step();
    check("t1_imem", imem_r_data, 32'h1234_5678);

    // Strobed store then load.
    do_init(2, 32'h0);
    do_write(32'h8, 4'b0101, 32'hAABB_CCDD);
    rd_check("t2", 32'h8, 32'h00BB_00DD);
    check("t2_store", 32'(store_cnt), 32'h1);
    check("t2_load", 32'(load_cnt), 32'h1);

    // Same-edge read+write returns old data.
    do_init(2, 32'h1);
    r_en  = 1'b1;
    w_en  = 1'b1;
    daddr = 32'h8;
    wdata = 32'hF;
    strb  = 4'hF;
    step();
    w_en = 1'b0;
    strb = 4'h0;
    step();
    r_en = 1'b0;
    check("t3_old", dmem_r_data, 32'h1);
    step();
    check("t3_new", dmem_r_data, 32'hF);

    // Out-of-range read and dropped write.
    rd_check("t4_oob", 32'h0010_0000, 32'hDEAD_BEEF);
    check("t4_err", 32'(err_oob), 32'h1);
    do_write(32'h0010_0000, 4'hF, 32'h9999_9999);
    step();
    check("t4_store", 32'(store_cnt), 32'h2);
    check("t4_err_sticky", 32'(err_oob), 32'h1);
    rd_check("t4_word0", 32'h0, pre0);

    // Preload beats a same-word store; a different-word store still commits.
    init_we = 1'b1; init_addr = 10'd3; init_data = 32'h3333_3333;
    do_write(32'hC, 4'hF, 32'h7777_7777);
    init_we = 1'b0;
    rd_check("t5_same", 32'hC, 32'h3333_3333);
    check("t5_store_same", 32'(store_cnt), 32'h2);
    init_we = 1'b1; init_addr = 10'd3; init_data = 32'h4444_4444;
    do_write(32'h10, 4'hF, 32'h5555_5555);
    init_we = 1'b0;
    rd_check("t5_diff", 32'h10, 32'h5555_5555);
    rd_check("t5_init", 32'hC, 32'h4444_4444);
    check("t5_store_diff", 32'(store_cnt), 32'h3);

    // Reset mid-stream flushes in-flight reads, keeps contents.
    r_en = 1'b1;
    daddr = 32'h10; step();
    daddr = 32'hC;  step();
    check("t6_v1", 32'(dmem_r_valid), 32'h1);
    daddr = 32'h8;  step();
    check("t6_v2", dmem_r_data, 32'h4444_4444);
    r_en  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(dmem_r_valid), 32'h0);
    check("t6_async_imem", imem_r_data, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("t6_no_valid", 32'(dmem_r_valid), 32'h0);
    end
    check("t6_load", 32'(load_cnt), 32'h0);
    check("t6_store", 32'(store_cnt), 32'h0);
    check("t6_err", 32'(err_oob), 32'h0);
    rd_check("t6_keep2", 32'h8, 32'hF);
    rd_check("t6_keep3", 32'hC, 32'h4444_4444);

    // Random traffic over 16 words with occasional OOB, preload and reset.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      r_en  = $urandom_range(0, 1) == 1;
      w_en  = $urandom_range(0, 1) == 1;
      strb  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        a = $urandom;
        if (a[31:DepthLog2+2] == '0) a[20] = 1'b1;
        daddr = a;
      end else begin
        daddr = 32'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 63) == 0) imem_addr = 32'h0040_0000 | 32'($urandom_range(0, 63));
      else imem_addr = 32'($urandom_range(0, 63));
      init_we   = $urandom_range(0, 7) == 0;
      init_addr = DepthLog2'($urandom_range(0, 15));
      init_data = $urandom;
      step();
    end
    idle();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_mem_model.md
Name: otter_mem_model

Overview:
Parametrised instruction/data memory model for bench and formal harnesses around otter_mcu. It replaces free-running random imem/dmem read data with a shared, byte-writable word array. It adds configurable read latency, a preload port, out-of-range detection and load/store counters. It is instantiated beside otter_mcu and connects directly to its imem_* and dmem_* ports.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (array covers byte addresses 0 .. 4*2^DEPTH_LOG2-1)
RD_LATENCY, 1, cycles from address sample to read data on both read ports; legal 1..4; elaboration error otherwise
OOB_DATA, 32'hDEAD_BEEF, read data returned for out-of-range addresses
CNT_W, 16, width of load/store counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
imem_addr  in  32  instruction fetch byte address; sampled every cycle
imem_r_data  out  32  fetched word, RD_LATENCY cycles after imem_addr
dmem_r_en  in  1  data read request
dmem_w_en  in  1  data write request
dmem_w_strb  in  4  byte lane enables; bit i writes bits 8i+7:8i
dmem_addr  in  32  data byte address
dmem_w_data  in  32  store data, already lane-aligned
dmem_r_data  out  32  load data, RD_LATENCY cycles after a dmem_r_en cycle
dmem_r_valid  out  1  high in the cycle dmem_r_data carries a load result
init_we  in  1  preload write enable (full word)
init_addr  in  DEPTH_LOG2  preload word index
init_data  in  32  preload word
err_oob  out  1  sticky: any access with an address beyond the array
load_cnt  out  CNT_W  count of accepted dmem reads
store_cnt  out  CNT_W  count of committed dmem writes

Behaviour:
- Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored; byte selection is by strobe only. Address is out-of-range (OOB) if any of addr[31:DEPTH_LOG2+2] is nonzero.
- Reset (rst=0, async): read pipelines cleared; imem_r_data=0, dmem_r_data=0, dmem_r_valid=0, err_oob=0, load_cnt=0, store_cnt=0. Array contents are not reset and keep their values across reset. Accesses are ignored while rst=0.
- Reads: each port has an RD_LATENCY-stage pipeline of {data, valid}. The array is read at the sampling edge, with read-old semantics: a write at the same edge to the same word is not visible. Stage 1 captures array[idx], or OOB_DATA if OOB. imem_r_data = last stage, updated every cycle.
- dmem_r_valid = last-stage valid bit. dmem_r_data = last-stage data when valid, else 32'h0.
- Back-to-back reads are fully pipelined: one result per cycle, with no bubbles.
- dmem_r_en and dmem_w_en both high: read and write are both performed. The read returns pre-write data.
- Writes commit at the rising edge when dmem_w_en=1, not OOB, and dmem_w_strb!=0. Only strobed lanes change.
  - dmem_w_en=1 with strb=0 is a no-op and is not counted.
  - An OOB write is dropped, sets err_oob and is not counted.
- init_we has priority over a dmem write to the same word index at the same edge: the dmem write is dropped and store_cnt does not increment. A dmem write to a different word at the same edge still commits.
- load_cnt increments on each sampled dmem_r_en=1 (OOB included); store_cnt increments on each committed write. Both wrap modulo 2^CNT_W.
- err_oob is set by any OOB imem fetch, OOB dmem read or OOB dmem write. It clears only on reset.
- Reset asserted mid-operation flushes in-flight reads: no dmem_r_valid pulse is produced after reset release for requests made before reset.

Test Plan:
1. Preload word 4 = 32'h1234_5678; imem_addr=0x10, RD_LATENCY=1 -> imem_r_data=32'h1234_5678 on the next cycle; with RD_LATENCY=3 it appears 3 cycles later.
2. Word 2 = 0; dmem write addr 0x8, strb=4'b0101, data 32'hAABB_CCDD; read 0x8 next cycle -> dmem_r_data=32'h00BB_00DD with dmem_r_valid=1; store_cnt=1, load_cnt=1.
3. Same-cycle read+write to addr 0x8 (old 32'h1, new 32'hF, strb=F) -> that read returns 32'h1; a following read returns 32'hF.
4. Read addr 0x0010_0000 with DEPTH_LOG2=10 -> dmem_r_data=32'hDEAD_BEEF and err_oob=1. A write to the same address leaves the array and store_cnt unchanged; err_oob stays 1 until rst=0.
5. init_we to word 3 and dmem write to addr 0xC at the same edge -> word 3 = init_data and store_cnt unchanged. Repeat with the dmem write to 0x10 -> both commit.
6. Issue reads on 3 consecutive cycles with RD_LATENCY=2, then assert rst=0 for 1 cycle after the 2nd valid -> all outputs are 0, no further dmem_r_valid, counters are 0 after release, and preloaded contents are intact.
